// File: rtl/regfile_integer_param_pkg.sv
// Shared types and helpers for the parametrised integer register file.
package regfile_integer_param_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // An address is usable only when it names an architectural register.
  function automatic logic addr_valid(input logic [RF_ADDR_W-1:0] addr, input int nregs);
    return int'({27'b0, addr}) < nregs;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: decode, x0/range zeroing, optional same-cycle write
// bypass (REGFILE_BYPASS_EN) and output flop.
module regfile_read_port
  import regfile_integer_param_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                        clk_i,
  input  logic                        resetb_i,
  input  logic                        en_i,
  input  logic                        run_i,
  input  logic                        rd_i,
  input  logic [RF_ADDR_W-1:0]        addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]  mem_i,
  input  logic                        wa_wr_i,
  input  logic [RF_ADDR_W-1:0]        wa_addr_i,
  input  logic [XLEN-1:0]             wa_data_i,
  input  logic                        wb_wr_i,
  input  logic [RF_ADDR_W-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]             wb_data_i,
  output logic [XLEN-1:0]             data_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] data_q, data_d;
  logic            hit_ok;

  assign hit_ok = addr_valid(addr_i, NREGS) && (addr_i != '0);

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      if (!run_i) begin
        data_d = '0;
      end else if (rd_i) begin
        data_d = '0;
        if (hit_ok) begin
          data_d = mem_i[addr_i[AW-1:0]];
`ifdef REGFILE_BYPASS_EN
          // Port b is applied last so it wins a double hit, matching write priority.
          if (wa_wr_i && (wa_addr_i == addr_i)) data_d = wa_data_i;
          if (wb_wr_i && (wb_addr_i == addr_i)) data_d = wb_data_i;
`endif
        end
      end
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wa_wr_i, wa_addr_i, wa_data_i, wb_wr_i, wb_addr_i, wb_data_i};
`endif

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) data_q <= '0;
    else           data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/regfile_integer_param.sv
// Parametrised integer register file with clear sequencer and two write ports.
// Optional same-cycle write-to-read bypass via macro REGFILE_BYPASS_EN.
module regfile_integer_param
  import regfile_integer_param_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                     clk_i,
  input  logic                     resetb_i,
  input  logic                     clk_en_i,
  input  logic                     clear_i,
  output logic                     ready_o,
  input  logic                     wreg_a_wr_i,
  input  logic [RF_ADDR_W-1:0]     wreg_a_addr_i,
  input  logic [XLEN-1:0]          wreg_a_data_i,
  input  logic                     wreg_b_wr_i,
  input  logic [RF_ADDR_W-1:0]     wreg_b_addr_i,
  input  logic [XLEN-1:0]          wreg_b_data_i,
  input  logic [NRD-1:0]           rreg_rd_i,
  input  logic [RF_ADDR_W*NRD-1:0] rreg_addr_i,
  output logic [XLEN*NRD-1:0]      rreg_data_o,
  output logic                     addr_err_o
);

  localparam int AW = $clog2(NREGS);

  rf_state_e                  state_q, state_d;
  logic [RF_ADDR_W-1:0]       clr_idx_q, clr_idx_d;
  logic                       ready_q, ready_d;
  logic                       err_q, err_d;
  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic                       wa_ok, wb_ok, wr_err, rd_err;

  assign wa_ok  = wreg_a_wr_i && addr_valid(wreg_a_addr_i, NREGS) && (wreg_a_addr_i != '0);
  assign wb_ok  = wreg_b_wr_i && addr_valid(wreg_b_addr_i, NREGS) && (wreg_b_addr_i != '0);
  assign wr_err = (wreg_a_wr_i && !addr_valid(wreg_a_addr_i, NREGS)) ||
                  (wreg_b_wr_i && !addr_valid(wreg_b_addr_i, NREGS));

  always_comb begin
    rd_err = 1'b0;
    for (int k = 0; k < NRD; k++)
      if (rreg_rd_i[k] && !addr_valid(rreg_addr_i[RF_ADDR_W*k +: RF_ADDR_W], NREGS))
        rd_err = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    err_d     = err_q;
    mem_d     = mem_q;
    mem_d[0]  = '0;
    if (clk_en_i) begin
      err_d = 1'b0;
      case (state_q)
        CLEAR: begin
          mem_d[clr_idx_q[AW-1:0]] = '0;
          clr_idx_d = clr_idx_q + RF_ADDR_W'(1);
          if (clr_idx_q == RF_ADDR_W'(NREGS-1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
        RUN: begin
          // Port b is applied after port a so it wins a same-address collision.
          if (wa_ok) mem_d[wreg_a_addr_i[AW-1:0]] = wreg_a_data_i;
          if (wb_ok) mem_d[wreg_b_addr_i[AW-1:0]] = wreg_b_data_i;
          err_d = wr_err || rd_err;
          if (clear_i) begin
            state_d   = CLEAR;
            clr_idx_d = RF_ADDR_W'(1);
            ready_d   = 1'b0;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= RF_ADDR_W'(1);
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Storage is zeroed by the sequencer rather than by reset.
  always_ff @(posedge clk_i) mem_q <= mem_d;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rd (
      .clk_i     (clk_i),
      .resetb_i  (resetb_i),
      .en_i      (clk_en_i),
      .run_i     (state_q == RUN),
      .rd_i      (rreg_rd_i[k]),
      .addr_i    (rreg_addr_i[RF_ADDR_W*k +: RF_ADDR_W]),
      .mem_i     (mem_q),
      .wa_wr_i   (wreg_a_wr_i),
      .wa_addr_i (wreg_a_addr_i),
      .wa_data_i (wreg_a_data_i),
      .wb_wr_i   (wreg_b_wr_i),
      .wb_addr_i (wreg_b_addr_i),
      .wb_data_i (wreg_b_data_i),
      .data_o    (rreg_data_o[XLEN*k +: XLEN])
    );
  end

  assign ready_o    = ready_q;
  assign addr_err_o = err_q;

endmodule

// File: tb/tb_regfile_integer_param.sv
// Bench for regfile_integer_param: a 32-register and a 16-register instance share
// stimulus and are checked against an array-based reference model.
module tb_regfile_integer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb, en, clr, wa_wr, wb_wr;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic [1:0]  rd;
  logic [9:0]  raddr;
  logic        rdy32, rdy16, err32, err16;
  logic [63:0] rdata32, rdata16;

  regfile_integer_param #(.XLEN(32), .NREGS(32), .NRD(2)) dut32 (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(en), .clear_i(clr), .ready_o(rdy32),
    .wreg_a_wr_i(wa_wr), .wreg_a_addr_i(wa_addr), .wreg_a_data_i(wa_data),
    .wreg_b_wr_i(wb_wr), .wreg_b_addr_i(wb_addr), .wreg_b_data_i(wb_data),
    .rreg_rd_i(rd), .rreg_addr_i(raddr), .rreg_data_o(rdata32), .addr_err_o(err32));

  regfile_integer_param #(.XLEN(32), .NREGS(16), .NRD(2)) dut16 (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(en), .clear_i(clr), .ready_o(rdy16),
    .wreg_a_wr_i(wa_wr), .wreg_a_addr_i(wa_addr), .wreg_a_data_i(wa_data),
    .wreg_b_wr_i(wb_wr), .wreg_b_addr_i(wb_addr), .wreg_b_data_i(wb_data),
    .rreg_rd_i(rd), .rreg_addr_i(raddr), .rreg_data_o(rdata16), .addr_err_o(err16));

  logic        o_rdy [2];
  logic        o_err [2];
  logic [31:0] o_rd  [2][2];
  always_comb begin
    o_rdy[0] = rdy32;  o_rdy[1] = rdy16;
    o_err[0] = err32;  o_err[1] = err16;
    o_rd[0][0] = rdata32[31:0];  o_rd[0][1] = rdata32[63:32];
    o_rd[1][0] = rdata16[31:0];  o_rd[1][1] = rdata16[63:32];
  end

  // Reference model: index 0 models NREGS=32, index 1 models NREGS=16.
  int          nr [2] = '{32, 16};
  logic [31:0] mm [2][32];
  bit          m_rdy [2];
  int          m_left [2];
  logic [31:0] m_rd [2][2];
  bit          m_err [2];
  int          n_tests = 0, n_fail = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = 0; m_left[d] = nr[d] - 1; m_err[d] = 0;
      m_rd[d][0] = '0; m_rd[d][1] = '0;
      for (int i = 0; i < 32; i++) mm[d][i] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (en) begin
        if (!m_rdy[d]) begin
          m_left[d]--;
          if (m_left[d] == 0) m_rdy[d] = 1;
          m_err[d] = 0; m_rd[d][0] = '0; m_rd[d][1] = '0;
        end else begin
          bit e;
          e = 0;
          for (int k = 0; k < 2; k++) begin
            if (rd[k]) begin
              int a;
              a = int'(raddr[5*k +: 5]);
              if (a >= nr[d]) e = 1;
              if (a == 0 || a >= nr[d]) m_rd[d][k] = '0;
              else begin
                m_rd[d][k] = mm[d][a];
`ifdef REGFILE_BYPASS_EN
                if (wa_wr && int'(wa_addr) == a) m_rd[d][k] = wa_data;
                if (wb_wr && int'(wb_addr) == a) m_rd[d][k] = wb_data;
`endif
              end
            end
          end
          if (wa_wr) begin
            if (int'(wa_addr) >= nr[d]) e = 1;
            else if (wa_addr != 0) mm[d][wa_addr] = wa_data;
          end
          if (wb_wr) begin
            if (int'(wb_addr) >= nr[d]) e = 1;
            else if (wb_addr != 0) mm[d][wb_addr] = wb_data;
          end
          m_err[d] = e;
          if (clr) begin
            m_rdy[d] = 0; m_left[d] = nr[d] - 1;
            for (int i = 0; i < 32; i++) mm[d][i] = '0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wa_wr = 0; wb_wr = 0; rd = '0;
    wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0; raddr = '0;
  endtask

  task automatic test_reset();
    en = 1; idle();
    resetb = 1; #1; resetb = 0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdy[d] !== 1'b0 || o_err[d] !== 1'b0 || o_rd[d][0] !== '0 || o_rd[d][1] !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: rdy=%b err=%b rd0=%h rd1=%h, want all 0",
                 d, o_rdy[d], o_err[d], o_rd[d][0], o_rd[d][1]);
      end
    end
    resetb = 1;
    model_reset();
  endtask

  task automatic test_clear_seq();
    for (int i = 1; i <= 31; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (o_rdy[d] !== (i >= nr[d] - 1)) begin
          n_fail++;
          $display("FAIL clear_ready dut%0d cycle %0d: got %b want %b", d, i, o_rdy[d], i >= nr[d] - 1);
        end
      end
    end
    for (int a = 1; a <= 31; a++) begin
      rd = 2'b11; raddr = {5'(32 - a), 5'(a)};
      tick();
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (o_rd[d][k] !== 32'h0 || o_rd[d][k] !== m_rd[d][k] || o_err[d] !== m_err[d]) begin
            n_fail++;
            $display("FAIL cleared_read dut%0d port%0d x%0d: got %h err=%b want 0 err=%b",
                     d, k, a, o_rd[d][k], o_err[d], m_err[d]);
          end
        end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle(); wa_wr = 1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    tick();
    idle(); rd = 2'b11; raddr = {5'd0, 5'd5};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rd[d][0] !== 32'hDEADBEEF || o_rd[d][1] !== 32'h0) begin
        n_fail++;
        $display("FAIL write_read dut%0d: got %h/%h want deadbeef/00000000", d, o_rd[d][0], o_rd[d][1]);
      end
    end
    idle();
  endtask

  task automatic test_collision();
    idle();
    wa_wr = 1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wb_wr = 1; wb_addr = 5'd7; wb_data = 32'h22222222;
    tick();
    idle(); rd = 2'b10; raddr = {5'd7, 5'd0};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rd[d][1] !== 32'h22222222) begin
        n_fail++;
        $display("FAIL collision dut%0d: got %h want 22222222", d, o_rd[d][1]);
      end
    end
    idle();
  endtask

  task automatic test_rw_same();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'hCAFEF00D;
`else
    want = 32'h0;
`endif
    idle(); rd = 2'b01; raddr = {5'd0, 5'd9};
    wa_wr = 1; wa_addr = 5'd9; wa_data = 32'hCAFEF00D;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rd[d][0] !== want) begin
        n_fail++;
        $display("FAIL rw_same dut%0d: got %h want %h", d, o_rd[d][0], want);
      end
    end
    idle(); rd = 2'b01; raddr = {5'd0, 5'd9};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rd[d][0] !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL rw_after dut%0d: got %h want cafef00d", d, o_rd[d][0]);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    idle(); wa_wr = 1; wa_addr = 5'd20; wa_data = 32'h1234;
    tick();
    n_tests++;
    if (err16 !== 1'b1 || err32 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_write_err: err16=%b err32=%b want 1/0", err16, err32);
    end
    idle(); rd = 2'b11; raddr = {5'd4, 5'd20};
    tick();
    n_tests++;
    if (rdata16[31:0] !== 32'h0 || err16 !== 1'b1 || rdata16[63:32] !== m_rd[1][1]) begin
      n_fail++;
      $display("FAIL oor_read16: x20=%h err=%b x4=%h want 0/1/%h",
               rdata16[31:0], err16, rdata16[63:32], m_rd[1][1]);
    end
    n_tests++;
    if (rdata32[31:0] !== 32'h1234 || err32 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_read32: x20=%h err=%b want 00001234/0", rdata32[31:0], err32);
    end
    idle();
    tick();
    n_tests++;
    if (err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_pulse: err16=%b want 0", err16);
    end
  endtask

  task automatic test_clear_req();
    int first [2];
    idle(); wb_wr = 1; wb_addr = 5'd3; wb_data = 32'hAA;
    tick();
    idle(); clr = 1;
    tick();
    clr = 0;
    first[0] = -1; first[1] = -1;
    for (int c = 1; c <= 100 && (first[0] < 0 || first[1] < 0); c++) begin
      en = !(c >= 10 && c <= 14);
      tick();
      for (int d = 0; d < 2; d++) if (first[d] < 0 && o_rdy[d] === 1'b1) first[d] = c;
    end
    en = 1;
    n_tests++;
    if (first[0] != 36 || first[1] != 20) begin
      n_fail++;
      $display("FAIL clear_len: ready after %0d/%0d cycles want 36/20", first[0], first[1]);
    end
    rd = 2'b01; raddr = {5'd0, 5'd3};
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rd[d][0] !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_x3 dut%0d: got %h want 0", d, o_rd[d][0]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int cnt;
    idle(); wa_wr = 1; wa_addr = 5'd6; wa_data = 32'h600D;
    tick();
    idle(); rd = 2'b01; raddr = {5'd0, 5'd6};
    tick();
    idle(); clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 10; i++) tick();
    resetb = 0; #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdy[d] !== 1'b0 || o_rd[d][0] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d: rdy=%b rd0=%h want 0/0", d, o_rdy[d], o_rd[d][0]);
      end
    end
    @(posedge clk); #1;
    resetb = 1;
    model_reset();
    cnt = 0;
    while (rdy32 !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != 31) begin
      n_fail++;
      $display("FAIL reset_mid_clear: ready after %0d cycles want 31", cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 79) == 0);
      wa_wr   = $urandom_range(0, 1);
      wb_wr   = $urandom_range(0, 1);
      wa_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wb_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa_data = $urandom;
      wb_data = $urandom;
      rd      = 2'($urandom);
      raddr   = {($urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom)),
                 ($urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom))};
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (o_rdy[d] !== m_rdy[d] || o_err[d] !== m_err[d] ||
            o_rd[d][0] !== m_rd[d][0] || o_rd[d][1] !== m_rd[d][1]) begin
          n_fail++;
          $display("FAIL random dut%0d step %0d: rdy=%b err=%b rd=%h/%h want rdy=%b err=%b rd=%h/%h",
                   d, i, o_rdy[d], o_err[d], o_rd[d][0], o_rd[d][1],
                   m_rdy[d], m_err[d], m_rd[d][0], m_rd[d][1]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_clear_seq();
    test_write_read();
    test_collision();
    test_rw_same();
    test_out_of_range();
    test_clear_req();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
